uart_rx_buffer: RTL and testbench

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

---
 rtl/uart_rx_buffer.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
// UART receiver (LSB first, one stop bit) feeding a first-word fall-through receive FIFO.
// Define UART_RX_PARITY_EN to expect and check one even-parity bit after the data bits.
module uart_rx_buffer #(
    parameter int unsigned DATA_BIT   = 8,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned ITEM_COUNT = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            rx,
    input  logic                            rd_en,
    output logic [DATA_BIT-1:0]             rd_data,
    output logic                            rd_valid,
    output logic [$clog2(ITEM_COUNT+1)-1:0] count,
    output logic                            full,
    output logic                            overrun,
    output logic                            frame_err,
    output logic                            parity_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W        = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
    localparam int unsigned PTR_W        = $clog2(ITEM_COUNT);
    localparam int unsigned FILL_W       = $clog2(ITEM_COUNT + 1);
`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} stateT;

    stateT               state, stateNext;
    logic                rxMeta, rxSync;
    logic [CNT_W-1:0]    bitCnt;
    logic [IDX_W-1:0]    bitIdx;
    logic [DATA_BIT-1:0] shiftReg;
    logic                bitDone;
    logic                cntClear, sampleData, pushFrame, frameErrSet;
`ifdef UART_RX_PARITY_EN
    logic                sampleParity, parityErrSet, parityBit, parityOk;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
        end
    end

    assign bitDone = (bitCnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bitCnt    <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= stateNext;
            frame_err <= frameErrSet;
            if (cntClear)
                bitCnt <= '0;
            else if (state != IDLE && state != BREAK)
                bitCnt <= bitCnt + CNT_W'(1);
            if (state == START)
                bitIdx <= '0;
            else if (sampleData)
                bitIdx <= bitIdx + IDX_W'(1);
            if (sampleData)
                shiftReg <= {rxSync, shiftReg[DATA_BIT-1:1]};
        end
    end

    always_comb begin
        stateNext   = state;
        cntClear    = 1'b0;
        sampleData  = 1'b0;
        pushFrame   = 1'b0;
        frameErrSet = 1'b0;
`ifdef UART_RX_PARITY_EN
        sampleParity = 1'b0;
        parityErrSet = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!rxSync) begin
                    stateNext = START;
                    cntClear  = 1'b1;
                end
            end
            START: begin
                if (bitCnt == CNT_W'(HALF_BIT)) begin
                    cntClear  = 1'b1;
                    stateNext = rxSync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bitDone) begin
                    cntClear   = 1'b1;
                    sampleData = 1'b1;
                    if (bitIdx == IDX_W'(DATA_BIT - 1))
                        stateNext = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bitDone) begin
                    cntClear  = 1'b1;
                    stateNext = STOP;
`ifdef UART_RX_PARITY_EN
                    sampleParity = 1'b1;
`endif
                end
            end
            STOP: begin
                if (bitDone) begin
                    cntClear = 1'b1;
                    if (!rxSync) begin
                        frameErrSet = 1'b1;
                        stateNext   = BREAK;
                    end else begin
                        stateNext = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (parityOk)
                            pushFrame = 1'b1;
                        else
                            parityErrSet = 1'b1;
`else
                        pushFrame = 1'b1;
`endif
                    end
                end
            end
            BREAK: begin
                if (rxSync)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data ones plus the parity bit must total an even number.
    assign parityOk = ((^shiftReg) == parityBit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parityBit  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= parityErrSet;
            if (sampleParity)
                parityBit <= rxSync;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    logic [DATA_BIT-1:0] mem [ITEM_COUNT];
    logic [PTR_W-1:0]    wrPtr, rdPtr;
    logic                doPush, doPop;

    // A pop on the same edge frees the slot, so a push into a full buffer still lands.
    assign doPop  = rd_en && rd_valid;
    assign doPush = pushFrame && (!full || doPop);

    always_ff @(posedge clk) begin
        if (doPush)
            mem[wrPtr] <= shiftReg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (doPush)
                wrPtr <= (wrPtr == PTR_W'(ITEM_COUNT - 1)) ? '0 : wrPtr + PTR_W'(1);
            if (doPop)
                rdPtr <= (rdPtr == PTR_W'(ITEM_COUNT - 1)) ? '0 : rdPtr + PTR_W'(1);
            if (doPush && !doPop)
                count <= count + FILL_W'(1);
            else if (doPop && !doPush)
                count <= count - FILL_W'(1);
            if (pushFrame && full && !doPop)
                overrun <= 1'b1;
            else if (doPop)
                overrun <= 1'b0;
        end
    end

    assign rd_data  = mem[rdPtr];
    assign rd_valid = (count != '0);
    assign full     = (count == FILL_W'(ITEM_COUNT));

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer: frames, glitch, framing error, overrun, mid-frame reset.
// Parity cases are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx_buffer;

    localparam int unsigned DATA_BIT   = 8;
    localparam int unsigned BAUD_RATE  = 115200;
    localparam int unsigned CLK_FREQ   = 50000000;
    localparam int unsigned ITEM_COUNT = 4;
    localparam int unsigned CPB        = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF       = CPB / 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] count;
    logic       full;
    logic       overrun;
    logic       frame_err;
    logic       parity_err;

    int checks = 0;
    int errors = 0;
    int feCnt  = 0;
    int peCnt  = 0;

    uart_rx_buffer #(
        .DATA_BIT  (DATA_BIT),
        .BAUD_RATE (BAUD_RATE),
        .CLK_FREQ  (CLK_FREQ),
        .ITEM_COUNT(ITEM_COUNT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .full      (full),
        .overrun   (overrun),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) feCnt++;
        if (parity_err) peCnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All line driving happens on falling clock edges.
    task automatic holdRx(input logic level, input int unsigned cycles);
        rx = level;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic sendHead(input logic [7:0] d, input logic par);
        holdRx(1'b0, CPB);
        for (int unsigned i = 0; i < DATA_BIT; i++)
            holdRx(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        holdRx(par, CPB);
`else
        if (par) rx = 1'b1;
`endif
    endtask

    task automatic sendFrame(input logic [7:0] d);
        sendHead(d, ^d);
        holdRx(1'b1, CPB);
    endtask

    task automatic popCheck(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(rd_data), 32'(exp));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xA5: stop bit sampled HALF+4 clocks into the stop bit; data visible right after
        sendHead(8'hA5, 1'b0);
        rx = 1'b1;
        repeat (HALF + 3) @(negedge clk);
        chk("a5_pre_count", 32'(count), 32'd0);
        @(negedge clk);
        chk("a5_valid", 32'(rd_valid), 32'd1);
        chk("a5_data", 32'(rd_data), 32'hA5);
        chk("a5_count", 32'(count), 32'd1);
        repeat (CPB - HALF - 4) @(negedge clk);
        popCheck("a5_pop", 8'hA5);
        chk("a5_empty", 32'(rd_valid), 32'd0);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("empty_pop_count", 32'(count), 32'd0);

        // 200-clock low glitch: shorter than half a bit, must be rejected
        holdRx(1'b0, 200);
        holdRx(1'b1, CPB);
        chk("glitch_count", 32'(count), 32'd0);
        chk("glitch_ferr", 32'(feCnt), 32'd0);

        // 0x3C with the stop bit held low for two bit times
        sendHead(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (HALF + 3) @(negedge clk);
        chk("fe_pre", 32'(frame_err), 32'd0);
        @(negedge clk);
        chk("fe_pulse", 32'(frame_err), 32'd1);
        @(negedge clk);
        chk("fe_post", 32'(frame_err), 32'd0);
        repeat (2 * CPB - HALF - 5) @(negedge clk);
        holdRx(1'b1, CPB);
        chk("fe_count", 32'(count), 32'd0);
        chk("fe_pulses", 32'(feCnt), 32'd1);
        sendFrame(8'h11);
        popCheck("after_fe", 8'h11);

        // Overrun: five frames into a four-entry buffer
        for (int unsigned i = 1; i <= 5; i++) begin
            sendFrame(8'(i));
            if (i == 4) begin
                chk("fill4_full", 32'(full), 32'd1);
                chk("fill4_ovr", 32'(overrun), 32'd0);
            end
        end
        chk("ovr_count", 32'(count), 32'd4);
        chk("ovr_full", 32'(full), 32'd1);
        chk("ovr_flag", 32'(overrun), 32'd1);
        popCheck("ovr_pop1", 8'h01);
        chk("ovr_cleared", 32'(overrun), 32'd0);
        chk("ovr_count3", 32'(count), 32'd3);
        sendFrame(8'h06);
        chk("refill_count", 32'(count), 32'd4);

        // Simultaneous push and pop while full
        sendHead(8'h07, ^8'h07);
        chk("sim_head", 32'(rd_data), 32'h02);
        rx = 1'b1;
        repeat (HALF + 3) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (CPB - HALF - 4) @(negedge clk);
        chk("sim_count", 32'(count), 32'd4);
        chk("sim_ovr", 32'(overrun), 32'd0);
        popCheck("pop_03", 8'h03);
        popCheck("pop_04", 8'h04);
        popCheck("pop_06", 8'h06);
        chk("left_count", 32'(count), 32'd1);
        chk("left_data", 32'(rd_data), 32'h07);

        // Reset in the middle of data bit 3 of 0x99, then a clean 0x5A
        holdRx(1'b0, CPB);
        for (int unsigned i = 0; i < 3; i++)
            holdRx(1'b1 & (8'h99 >> i), CPB);
        holdRx(1'b1, HALF);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_ovr", 32'(overrun), 32'd0);
        chk("mid_rst_ferr", 32'(frame_err), 32'd0);
        chk("mid_rst_perr", 32'(parity_err), 32'd0);
        rst_n = 1'b1;
        holdRx(1'b1, 2 * CPB);
        chk("post_rst_count", 32'(count), 32'd0);
        sendFrame(8'h5A);
        chk("post_rst_count1", 32'(count), 32'd1);
        popCheck("post_rst", 8'h5A);

`ifdef UART_RX_PARITY_EN
        sendHead(8'h07, 1'b0);
        holdRx(1'b1, CPB);
        chk("par_bad_count", 32'(count), 32'd0);
        chk("par_bad_pulses", 32'(peCnt), 32'd1);
        sendHead(8'h07, 1'b1);
        holdRx(1'b1, CPB);
        chk("par_ok_count", 32'(count), 32'd1);
        chk("par_ok_pulses", 32'(peCnt), 32'd1);
        popCheck("par_ok", 8'h07);
`else
        chk("no_parity_err", 32'(peCnt), 32'd0);
`endif
        chk("final_ferr_pulses", 32'(feCnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
